qe_input_filter: RTL
====================

QE_INPUT_FILTER -- requirements
Module: qe_input_filter

Interface
REQ-001 Parameter: CNT_W, 4, width of filter_length and of each per-channel stability counter.
REQ-002 Parameter: ERR_W, 8, width of error_count.
REQ-003 clk  input  1  system clock; all state changes on its rising edge.
REQ-004 reset  input  1  synchronous, active-high reset.
REQ-005 QE_A_in, QE_B_in, QE_I_in  input  1 each  already-synchronised encoder signals.
REQ-006 filter_length  input  CNT_W  required extra stable samples before a level is accepted.
REQ-007 clear_errors  input  1  single-cycle pulse that zeroes error_count.
REQ-008 QE_A, QE_B, QE_I  output  1 each  filtered encoder signals, registered.
REQ-009 step  output  1  single-cycle pulse on each legal quadrature transition of filtered A/B.
REQ-010 direction  output  1  1 = CW, 0 = CCW; valid while step=1 and held until the next step.
REQ-011 illegal  output  1  single-cycle pulse when filtered A and B both change in the same cycle.
REQ-012 error_count  output  ERR_W  saturating count of illegal events.

Function
REQ-013 Each of A, B, I SHALL have an independent filter: registered output, CNT_W-bit counter.
REQ-014 Filter rule: input == output -> counter cleared to 0.
REQ-015 Filter rule: input != output and counter < filter_length -> counter increments.
REQ-016 Filter rule: input != output and counter >= filter_length -> output takes the input value and the counter clears.
REQ-017 Latency: a level held for filter_length+1 consecutive clocks SHALL appear on the output on the following edge.
REQ-018 filter_length=0 SHALL give a one-clock registered pass-through.
REQ-019 A glitch shorter than filter_length+1 clocks SHALL never reach the output.
REQ-020 filter_length changes SHALL take effect immediately; a counter already >= the new value commits on the next mismatching cycle.
REQ-021 Counter arithmetic SHALL never wrap: at most filter_length, max 2^CNT_W-1.
REQ-022 Quadrature FSM states: INIT, S00, S10, S11, S01 (named {A,B}).
REQ-023 CW sequence: S00->S10->S11->S01->S00.
REQ-024 CCW sequence: the reverse of REQ-023.
REQ-025 INIT: next cycle SHALL load filters directly from the inputs, bypassing filtering, and enter the state matching those inputs, with no step and no illegal.
REQ-026 In S-states, a filtered A/B change by one bit: move to the new state, assert step for one cycle, set direction per REQ-023/REQ-024.
REQ-027 In S-states, a filtered A/B change by two bits: move to the new state, assert illegal for one cycle, no step, direction unchanged.
REQ-028 step and illegal SHALL be registered, asserted in the same cycle the filtered outputs change, and never both high.
REQ-029 error_count SHALL increment on illegal and saturate at 2^ERR_W-1.
REQ-030 clear_errors coincident with illegal SHALL give error_count=0 (clear wins).
REQ-031 QE_I SHALL be filtered only and SHALL not affect the FSM.

Reset
REQ-032 On reset: QE_A/QE_B/QE_I=0, all counters=0, step=0, illegal=0, direction=0, error_count=0, FSM=INIT.
REQ-033 Reset asserted mid-filter or mid-sequence SHALL discard all pending counts; no step or illegal pulse in the cycle after reset.

Configuration
REQ-034 Macro QE_FILTER_ERROR_COUNT_EN defined: error_count and clear_errors behave per REQ-029/REQ-030.
REQ-035 Macro QE_FILTER_ERROR_COUNT_EN undefined: no counter register is built; error_count is tied to 0 and clear_errors is ignored.
REQ-036 Without QE_FILTER_ERROR_COUNT_EN, the illegal pulse and all other behaviour SHALL be unchanged.

Verification
REQ-037 Reset release with inputs A=1,B=1 -> next cycle QE_A=QE_B=1, FSM S11, step=0, illegal=0.
REQ-038 filter_length=3, A rises and is held for 4 clocks -> QE_A rises on the 5th edge; a 3-clock pulse on A -> QE_A stays 0.
REQ-039 filter_length=0, drive CW sequence 00,10,11,01,00 at 2 clocks/phase -> 4 step pulses, direction=1, illegal never asserted.
REQ-040 Same test as REQ-039 with CCW sequence 00,01,11,10,00 -> 4 step pulses, direction=0.
REQ-041 From S00, A and B rise in the same cycle -> illegal=1 for one cycle, step=0, error_count 0->1; 300 such events -> error_count=255 (macro defined) or 0 (macro undefined).
REQ-042 clear_errors coincident with an illegal pulse -> error_count=0; reset mid-filter (count=2 of 3) -> no output change after release.

Source files
------------

// File: rtl/qe_input_filter.sv
// qe_input_filter
//   Quadrature encoder front end: per-channel glitch filters on A, B and
//   index I, followed by a quadrature decoder that emits step/direction
//   pulses and flags illegal double-edge transitions.
//
//   Optional feature macro: QE_FILTER_ERROR_COUNT_EN
//     defined   -> saturating illegal-event counter, clear_errors zeroes it
//     undefined -> no counter register, error_count tied to 0
//
// Ports
//   clk, reset          clock, synchronous active-high reset
//   QE_A_in/B_in/I_in   synchronised encoder inputs
//   filter_length       extra stable samples needed before a level is taken
//   clear_errors        pulse, zeroes error_count (wins over increment)
//   QE_A/QE_B/QE_I      filtered, registered encoder signals
//   step                one-cycle pulse per legal A/B transition
//   direction           1 = CW, 0 = CCW, held between steps
//   illegal             one-cycle pulse when A and B change together
//   error_count         saturating count of illegal events

// One filter channel. out_d_o exposes next-state so the decoder can
// register step/illegal in the same edge the filtered level changes.
module qe_filter_ch #(
  parameter int CNT_W = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_i,
  input  logic [CNT_W-1:0] len_i,
  input  logic             load_i,
  output logic             out_d_o,
  output logic             out_q_o
);
  logic             out_q, out_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    out_d = out_q;
    cnt_d = '0;
    if (load_i) begin
      // first cycle after reset: take the raw level, no filtering
      out_d = in_i;
    end else if (in_i != out_q) begin
      // counter only grows while below len, so it can never wrap
      if (cnt_q >= len_i) out_d = in_i;
      else                cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      out_q <= 1'b0;
      cnt_q <= '0;
    end else begin
      out_q <= out_d;
      cnt_q <= cnt_d;
    end
  end

  assign out_d_o = out_d;
  assign out_q_o = out_q;
endmodule

module qe_input_filter #(
  parameter int CNT_W = 4,
  parameter int ERR_W = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             QE_A_in,
  input  logic             QE_B_in,
  input  logic             QE_I_in,
  input  logic [CNT_W-1:0] filter_length,
  input  logic             clear_errors,
  output logic             QE_A,
  output logic             QE_B,
  output logic             QE_I,
  output logic             step,
  output logic             direction,
  output logic             illegal,
  output logic [ERR_W-1:0] error_count
);
  localparam int NCH = 3;  // lane 0 = A, 1 = B, 2 = I

  typedef enum logic [2:0] {INIT, S00, S10, S11, S01} state_t;

  state_t           state_q, state_d;
  logic             step_q, step_d, illegal_q, illegal_d, dir_q, dir_d;
  logic             load;
  logic [NCH-1:0]   ch_in, ch_d, ch_q;
  logic [1:0]       ab_cur, ab_nxt, ab_diff;

  assign ch_in = {QE_I_in, QE_B_in, QE_A_in};
  assign load  = (state_q == INIT);

  for (genvar g = 0; g < NCH; g++) begin : g_ch
    qe_filter_ch #(.CNT_W(CNT_W)) u_ch (
      .clk     (clk),
      .reset   (reset),
      .in_i    (ch_in[g]),
      .len_i   (filter_length),
      .load_i  (load),
      .out_d_o (ch_d[g]),
      .out_q_o (ch_q[g])
    );
  end

  function automatic state_t state_of(input logic [1:0] ab);
    case (ab)
      2'b00:   state_of = S00;
      2'b10:   state_of = S10;
      2'b11:   state_of = S11;
      default: state_of = S01;
    endcase
  endfunction

  function automatic logic [1:0] ab_of(input state_t s);
    case (s)
      S10:     ab_of = 2'b10;
      S11:     ab_of = 2'b11;
      S01:     ab_of = 2'b01;
      default: ab_of = 2'b00;
    endcase
  endfunction

  // CW successor of an {A,B} code: 00 -> 10 -> 11 -> 01 -> 00
  function automatic logic [1:0] cw_next(input logic [1:0] ab);
    cw_next = {~ab[0], ab[1]};
  endfunction

  assign ab_cur  = ab_of(state_q);
  assign ab_nxt  = {ch_d[0], ch_d[1]};
  assign ab_diff = ab_cur ^ ab_nxt;

  always_comb begin
    state_d   = state_q;
    step_d    = 1'b0;
    illegal_d = 1'b0;
    dir_d     = dir_q;
    if (state_q == INIT) begin
      state_d = state_of(ab_nxt);
    end else if (ab_diff == 2'b11) begin
      state_d   = state_of(ab_nxt);
      illegal_d = 1'b1;
    end else if (ab_diff != 2'b00) begin
      state_d = state_of(ab_nxt);
      step_d  = 1'b1;
      dir_d   = (ab_nxt == cw_next(ab_cur));
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= INIT;
      step_q    <= 1'b0;
      illegal_q <= 1'b0;
      dir_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      step_q    <= step_d;
      illegal_q <= illegal_d;
      dir_q     <= dir_d;
    end
  end

`ifdef QE_FILTER_ERROR_COUNT_EN
  logic [ERR_W-1:0] err_q, err_d;

  // counts on the same edge that raises illegal; clear has priority
  always_comb begin
    err_d = err_q;
    if (clear_errors)                 err_d = '0;
    else if (illegal_d && !(&err_q))  err_d = err_q + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (reset) err_q <= '0;
    else       err_q <= err_d;
  end

  assign error_count = err_q;
`else
  logic unused_clear;
  assign unused_clear = clear_errors;
  assign error_count  = '0;
`endif

  assign QE_A      = ch_q[0];
  assign QE_B      = ch_q[1];
  assign QE_I      = ch_q[2];
  assign step      = step_q;
  assign illegal   = illegal_q;
  assign direction = dir_q;
endmodule
